// File: rtl/ram_sp_arb_pkg.sv
// Shared types and helpers for the round-robin RAM arbiter.
// Optional checker enabled by RAM_SP_ARB_CHK_EN.
package ram_sp_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int rd_lat(input int pipe);
    return pipe + 1;
  endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM with registered read and DOUT_PIPE_NUMBER output stages.
// Read latency from en to dout_valid is DOUT_PIPE_NUMBER+1 edges.
module ram_sp #(
  parameter int DATA_WIDTH       = 36,
  parameter int ADDR_WIDTH       = 12,
  parameter int RAM_DEPTH        = 1 << ADDR_WIDTH,
  parameter int DOUT_PIPE_NUMBER = 4
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  localparam int P = DOUT_PIPE_NUMBER;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [P:0][DATA_WIDTH-1:0] pd;
  logic [P:0]                 pv;

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= din;
    pd[0] <= mem[addr];
    pv[0] <= en && !we;
    for (int i = 1; i <= P; i++) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
  end

  assign dout       = pd[P];
  assign dout_valid = pv[P];

endmodule

// File: rtl/ram_sp_arb_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter
  import ram_sp_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  int            j;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_sp_arb.sv
// Round-robin share of one ram_sp with init sweep and in-order read tags.
// RAM_SP_ARB_CHK_EN enables the sticky tag/ram_dout_valid checker on err.
module ram_sp_arb
  import ram_sp_arb_pkg::*;
#(
  parameter int                    NUM_REQ          = 4,
  parameter int                    DATA_WIDTH       = 36,
  parameter int                    ADDR_WIDTH       = 14,
  parameter int                    RAM_DEPTH        = 4096,
  parameter int                    DOUT_PIPE_NUMBER = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE       = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          init_done,
  output logic                          err,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic [DATA_WIDTH-1:0]         ram_dout,
  input  logic                          ram_dout_valid
);

  localparam int RD_LAT = rd_lat(DOUT_PIPE_NUMBER);
  localparam int IW     = id_w(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                    state, state_nx;
  logic                      run;
  logic [ADDR_WIDTH-1:0]     cnt;
  logic [IW-1:0]             rr_ptr, ptr_nx;
  logic [NUM_REQ-1:0]        req_m, gnt;
  logic [IW-1:0]             gnt_idx;
  logic                      gnt_any;
  logic                      sel_we;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0]     sel_din;
  logic [RD_LAT:0]           tag_v;
  logic [RD_LAT:0][IW-1:0]   tag_id;

  assign run   = (state == RUN);
  assign req_m = run ? req_valid : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_m),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;
  assign sel_we    = req_we[gnt_idx];
  assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_din   = req_din[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_nx    = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT:    if (cnt == LAST) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      init_done <= 1'b0;
      rr_ptr    <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      tag_v     <= '0;
      tag_id    <= '0;
    end else begin
      init_done <= run;
      if (!run) begin
        ram_en   <= 1'b1;
        ram_we   <= 1'b1;
        ram_addr <= cnt;
        ram_din  <= INIT_VALUE;
        cnt      <= cnt + 1'b1;
      end else begin
        ram_en <= gnt_any;
        ram_we <= gnt_any & sel_we;
        if (gnt_any) begin
          ram_addr <= sel_addr;
          ram_din  <= sel_din;
          rr_ptr   <= ptr_nx;
        end
      end
      // stage 0 lands with ram_en; last stage lines up with ram_dout_valid
      tag_v  <= {tag_v[RD_LAT-1:0], gnt_any & ~sel_we};
      tag_id <= {tag_id[RD_LAT-1:0], gnt_idx};
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tag_v[RD_LAT]) begin
      rsp_valid[tag_id[RD_LAT]] = 1'b1;
      rsp_data                  = ram_dout;
    end
  end

`ifdef RAM_SP_ARB_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (run && (tag_v[RD_LAT] != ram_dout_valid))
      err <= 1'b1;
  end
`else
  logic unused_dv;
  assign unused_dv = ram_dout_valid;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sp_arb.sv
// Random + directed bench for ram_sp_arb against a memory/queue model.
module tb_ram_sp_arb;

  localparam int N      = 4;
  localparam int DW     = 36;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int PIPE   = 2;
  localparam int RD_LAT = PIPE + 1;
  localparam logic [DW-1:0] IV = 36'h9_5A5A_C3C3;

`ifdef RAM_SP_ARB_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_din = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            init_done, err;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din, ram_dout;
  logic            dv_raw, dv;
  logic            force_dv = 1'b0;

  assign dv = dv_raw | force_dv;

  always #5 clk = ~clk;

  ram_sp_arb #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
    .DOUT_PIPE_NUMBER(PIPE), .INIT_VALUE(IV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .init_done(init_done), .err(err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_dout_valid(dv)
  );

  ram_sp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
    .DOUT_PIPE_NUMBER(PIPE)
  ) u_ram (
    .clk(clk), .en(ram_en), .we(ram_we), .addr(ram_addr),
    .din(ram_din), .dout(ram_dout), .dout_valid(dv_raw)
  );

  typedef struct {
    int          id;
    logic [DW-1:0] data;
    int          due;
  } rsp_t;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            ptr;
  logic [DW-1:0] mdl [DEPTH];
  rsp_t          q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_rsp();
    logic [N-1:0] e;
    e = '0;
    if (q.size() > 0 && q[0].due < cyc) begin
      check("rsp_missing", 64'(q[0].due), 64'(cyc));
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e[q[0].id] = 1'b1;
      check("rsp_valid", 64'(rsp_valid), 64'(e));
      check("rsp_data", 64'(rsp_data), 64'(q[0].data));
      void'(q.pop_front());
    end else begin
      check("rsp_idle", 64'(rsp_valid), 64'(e));
    end
  endtask

  // One cycle in RUN: drive, check grant, advance the model.
  task automatic cycle_run(input logic [N-1:0] v, input logic [N-1:0] we,
                           input logic [N*AW-1:0] a,
                           input logic [N*DW-1:0] d, output int g);
    logic [N-1:0]  eg;
    logic [AW-1:0] ga;
    @(negedge clk);
    chk_rsp();
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_din   = d;
    #1;
    g  = -1;
    eg = '0;
    for (int i = 0; i < N; i++)
      if (g < 0 && v[(ptr + i) % N]) g = (ptr + i) % N;
    if (g >= 0) eg[g] = 1'b1;
    check("grant", 64'(req_ready), 64'(eg));
    if (g >= 0) begin
      ga = a[g*AW +: AW];
      if (we[g]) mdl[ga] = d[g*DW +: DW];
      else q.push_back('{g, mdl[ga], cyc + RD_LAT + 1});
      ptr = (g + 1) % N;
    end
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) cycle_run('0, '0, '0, '0, g);
  endtask

  task automatic one(input int r, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    logic [N-1:0]    v, we;
    logic [N*AW-1:0] av;
    logic [N*DW-1:0] dv_;
    int              g;
    v  = '0;
    we = '0;
    av = '0;
    dv_ = '0;
    v[r]  = 1'b1;
    we[r] = w;
    av[r*AW +: AW] = a;
    dv_[r*DW +: DW] = d;
    cycle_run(v, we, av, dv_, g);
    check("one_gnt", 64'(g), 64'(r));
  endtask

  task automatic rand_vec(output logic [N*AW-1:0] a, output logic [N*DW-1:0] d);
    a = (N*AW)'($urandom);
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'({$urandom, $urandom});
  endtask

  task automatic init_seq();
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("init_rsp", 64'(rsp_valid), 64'(0));
      if (k <= 16) begin
        check("init_en", 64'({ram_en, ram_we}), 64'(2'b11));
        check("init_addr", 64'(ram_addr), 64'(k - 1));
        check("init_din", 64'(ram_din), 64'(IV));
        check("init_done_lo", 64'(init_done), 64'(0));
      end else begin
        check("init_done_hi", 64'(init_done), 64'(1));
        check("init_idle_en", 64'(ram_en), 64'(0));
      end
      if (k <= 15) check("init_ready", 64'(req_ready), 64'(0));
      if (k == 15) req_valid = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '1;
    rst_n = 1'b0;
    #2;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rsp", 64'({rsp_valid, rsp_data}), 64'(0));
    check("rst_flags", 64'({init_done, err}), 64'(0));
    check("rst_ram", 64'({ram_en, ram_we, ram_addr}), 64'(0));
    check("rst_din", 64'(ram_din), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    ptr = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = IV;
    init_seq();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    int              g;

    // reset, sweep, read of an init-cleared address
    do_reset();
    one(0, 1'b0, 4'd5, '0);
    idle(RD_LAT + 2);
    check("err_after_init", 64'(err), 64'(0));

    // single requester write then read of the same word
    one(1, 1'b1, 4'd3, 36'hA5);
    one(1, 1'b0, 4'd3, '0);
    idle(RD_LAT + 2);

    // realign pointer to 0, then all four requesting for 8 cycles
    one(3, 1'b1, 4'd0, 36'h1234);
    for (int i = 0; i < 8; i++) begin
      rand_vec(a, d);
      cycle_run('1, N'($urandom), a, d, g);
      check("fair", 64'(g), 64'(i % N));
    end
    idle(RD_LAT + 2);

    // read A, write B, read B back-to-back
    one(0, 1'b1, 4'd9, 36'h0_DEAD_0009);
    idle(1);
    one(0, 1'b0, 4'd7, '0);
    one(2, 1'b1, 4'd9, 36'h0_BEEF_0B0B);
    one(0, 1'b0, 4'd9, '0);
    idle(RD_LAT + 2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_vec(a, d);
      cycle_run(N'($urandom), N'($urandom), a, d, g);
    end
    idle(RD_LAT + 2);

    // reset while three reads are in flight
    one(0, 1'b0, 4'd1, '0);
    one(1, 1'b0, 4'd2, '0);
    one(2, 1'b0, 4'd3, '0);
    do_reset();
    idle(RD_LAT + 4);
    check("err_after_rst", 64'(err), 64'(0));

    for (int i = 0; i < 60; i++) begin
      rand_vec(a, d);
      cycle_run(N'($urandom), N'($urandom), a, d, g);
    end
    idle(RD_LAT + 2);

    // spurious ram_dout_valid with no tag in flight
    @(negedge clk);
    check("err_pre", 64'(err), 64'(0));
    force_dv = 1'b1;
    @(negedge clk);
    force_dv = 1'b0;
    check("err_set", 64'(err), 64'(ERR_EXP));
    idle(5);
    check("err_sticky", 64'(err), 64'(ERR_EXP));
    do_reset();
    check("err_cleared", 64'(err), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
